// File: rtl/fireboy_sprite_animator.sv
`timescale 1ns/1ps
// Fireboy walk animation and sprite-ROM address/pixel pipeline (3 Clk latency).
// Turns upstream hit/address/direction into ROM reads and palette index + opacity.
//
// state     | meaning
// ST_IDLE   | standing still, frame_idx 0, counters held at 0
// ST_WALK_R | walking right, frame_idx 1..WALK_FRAMES
// ST_WALK_L | walking left, frame_idx WALK_FRAMES+1..2*WALK_FRAMES
module fireboy_sprite_animator #(
  parameter int         SPRITE_PIXELS   = 3600,
  parameter int         WALK_FRAMES     = 4,
  parameter int         FRAME_DIV       = 8,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        is_sprite,
  input  logic [11:0] sprite_address,
  input  logic [3:0]  sprite_direction,
  output logic [14:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  pix_index,
  output logic        pix_opaque,
  output logic [1:0]  anim_state
);

  localparam int FRAME_W = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
  localparam int TICK_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int IDX_W   = $clog2(2 * WALK_FRAMES + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(WALK_FRAMES - 1);
  localparam logic [IDX_W-1:0]   IDX_R_BASE = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_L_BASE = IDX_W'(1 + WALK_FRAMES);
  localparam logic [14:0]        PIX_STRIDE = 15'(SPRITE_PIXELS);

  localparam logic [3:0] DIR_LEFT  = 4'd3;
  localparam logic [3:0] DIR_RIGHT = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK_R = 2'd1,
    ST_WALK_L = 2'd2
  } anim_state_t;

  anim_state_t          state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [FRAME_W-1:0]   walk_frame_q, walk_frame_d;
  logic [IDX_W-1:0]     frame_idx_q, frame_idx_d;

  logic frame_clk_delayed;
  logic frame_edge;
  logic v1, v2;
  logic opaque_d;

  // Same detector as the upstream motion block, so direction is valid on this pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_delayed <= 1'b0;
      frame_edge        <= 1'b0;
    end else begin
      frame_clk_delayed <= frame_clk;
      frame_edge        <= frame_clk & ~frame_clk_delayed;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      walk_frame_q <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      walk_frame_q <= walk_frame_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    walk_frame_d = walk_frame_q;
    if (frame_edge) begin
      case (sprite_direction)
        DIR_RIGHT: state_d = ST_WALK_R;
        DIR_LEFT:  state_d = ST_WALK_L;
        default:   state_d = ST_IDLE;
      endcase
      if (state_d != state_q || state_d == ST_IDLE) begin
        tick_d       = '0;
        walk_frame_d = '0;
      end else if (tick_q == TICK_LAST) begin
        tick_d       = '0;
        walk_frame_d = (walk_frame_q == FRAME_LAST) ? '0 : walk_frame_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_comb begin
    frame_idx_d = '0;
    case (state_q)
      ST_WALK_R: frame_idx_d = IDX_R_BASE + IDX_W'(walk_frame_q);
      ST_WALK_L: frame_idx_d = IDX_L_BASE + IDX_W'(walk_frame_q);
      default:   frame_idx_d = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) frame_idx_q <= '0;
    else       frame_idx_q <= frame_idx_d;
  end

  // The address is formed even off-sprite; v1/v2 carry the hit flag alongside the ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
    end else begin
      rom_addr <= 15'(frame_idx_q) * PIX_STRIDE + 15'(sprite_address);
      v1       <= is_sprite;
      v2       <= v1;
    end
  end

  assign opaque_d = v2 & (rom_data != TRANSPARENT_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_opaque <= 1'b0;
      pix_index  <= '0;
    end else begin
      pix_opaque <= opaque_d;
      pix_index  <= opaque_d ? rom_data : 4'd0;
    end
  end

  assign anim_state = state_q;

endmodule

// File: tb/tb_fireboy_sprite_animator.sv
`timescale 1ns/1ps
// Self-checking bench for fireboy_sprite_animator with a synchronous ROM model.
module tb_fireboy_sprite_animator;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic        is_sprite;
  logic [11:0] sprite_address;
  logic [3:0]  sprite_direction;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pix_index;
  logic        pix_opaque;
  logic [1:0]  anim_state;

  int tests_run    = 0;
  int tests_failed = 0;

  fireboy_sprite_animator dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_clk        (frame_clk),
    .is_sprite        (is_sprite),
    .sprite_address   (sprite_address),
    .sprite_direction (sprite_direction),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .pix_index        (pix_index),
    .pix_opaque       (pix_opaque),
    .anim_state       (anim_state)
  );

  always #5 Clk = ~Clk;

  // ROM contents: low nibble of address plus 3, so address ...13 maps to index 0.
  function automatic logic [3:0] rom_fn(input logic [14:0] a);
    return a[3:0] + 4'd3;
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  task automatic frame_pulse(input logic [3:0] dir);
    sprite_direction = dir;
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; is_sprite = 1'b1; sprite_address = 12'd0;
    sprite_direction = 4'd5; frame_clk = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk); #1;
      tests_run++;
      if (anim_state !== 2'd0 || rom_addr !== 15'd0 || pix_opaque !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: state=%0d addr=%0d opq=%0b, want 0/0/0", c, anim_state, rom_addr, pix_opaque);
      end
    end
    frame_clk = 1'b0; Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      tests_run++;
      if (anim_state !== 2'd0 || rom_addr !== 15'd0 || pix_opaque !== (c == 2)) begin
        tests_failed++;
        $display("FAIL reset_release cyc%0d: state=%0d addr=%0d opq=%0b, want 0/0/%0b", c, anim_state, rom_addr, pix_opaque, c == 2);
      end
    end
    tests_run++;
    if (pix_index !== 4'd3) begin
      tests_failed++;
      $display("FAIL reset_first_pixel: pix_index=%0d want 3", pix_index);
    end
  endtask

  task automatic test_lookup();
    logic [11:0] addrs [4] = '{12'd100, 12'd101, 12'd3599, 12'd2047};
    logic [14:0] aq[$];
    logic [4:0]  pq[$];
    logic [14:0] ea;
    logic [4:0]  ep;
    logic [3:0]  d;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        is_sprite = 1'b1; sprite_address = addrs[k];
        d = rom_fn(15'(addrs[k]));
        aq.push_back(15'(addrs[k]));
        pq.push_back({d != 4'd0, (d != 4'd0) ? d : 4'd0});
      end
      @(posedge Clk); #1;
      if (k < 4) begin
        ea = aq.pop_front();
        tests_run++;
        if (rom_addr !== ea) begin
          tests_failed++;
          $display("FAIL lookup_addr item%0d: rom_addr=%0d want %0d", k, rom_addr, ea);
        end
      end
      if (k >= 2) begin
        ep = pq.pop_front();
        tests_run++;
        if ({pix_opaque, pix_index} !== ep) begin
          tests_failed++;
          $display("FAIL lookup_pix item%0d: opq=%0b idx=%0d want opq=%0b idx=%0d", k - 2, pix_opaque, pix_index, ep[4], ep[3:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [5] = '{12'd13, 12'd6, 12'd100, 12'd6, 12'd29};
    logic        vis   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [14:0] aq[$];
    logic [4:0]  pq[$];
    logic [14:0] ea;
    logic [4:0]  ep;
    logic [3:0]  d;
    logic        o;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        is_sprite = vis[k]; sprite_address = addrs[k];
        d = rom_fn(15'(addrs[k]));
        o = vis[k] && (d != 4'd0);
        aq.push_back(15'(addrs[k]));
        pq.push_back({o, o ? d : 4'd0});
      end else begin
        is_sprite = 1'b0;
      end
      @(posedge Clk); #1;
      if (k < 5) begin
        ea = aq.pop_front();
        tests_run++;
        if (rom_addr !== ea) begin
          tests_failed++;
          $display("FAIL b2b_addr item%0d: rom_addr=%0d want %0d", k, rom_addr, ea);
        end
      end
      if (k >= 2) begin
        ep = pq.pop_front();
        tests_run++;
        if ({pix_opaque, pix_index} !== ep) begin
          tests_failed++;
          $display("FAIL b2b_pix item%0d: opq=%0b idx=%0d want opq=%0b idx=%0d", k - 2, pix_opaque, pix_index, ep[4], ep[3:0]);
        end
      end
    end
  endtask

  task automatic test_walk_right();
    int exp_idx;
    sprite_address = 12'd0; is_sprite = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      frame_pulse(4'd5);
      exp_idx = 1 + ((n - 1) / 8) % 4;
      tests_run++;
      if (anim_state !== 2'd1 || rom_addr !== 15'(exp_idx * 3600)) begin
        tests_failed++;
        $display("FAIL walk_right edge%0d: state=%0d addr=%0d want 1/%0d", n, anim_state, rom_addr, exp_idx * 3600);
      end
    end
  endtask

  task automatic test_walk_left_wrap();
    int exp_idx;
    sprite_address = 12'd3599;
    for (int n = 1; n <= 33; n++) begin
      frame_pulse(4'd3);
      exp_idx = 5 + ((n - 1) / 8) % 4;
      tests_run++;
      if (anim_state !== 2'd2 || rom_addr !== 15'(exp_idx * 3600 + 3599)) begin
        tests_failed++;
        $display("FAIL walk_left edge%0d: state=%0d addr=%0d want 2/%0d", n, anim_state, rom_addr, exp_idx * 3600 + 3599);
      end
    end
  endtask

  task automatic test_direction_change();
    logic [3:0]  dirs  [15] = '{4'd5, 4'd5, 4'd5, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5};
    logic [1:0]  st    [15] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
    int          idx   [15] = '{1, 1, 1, 5, 5, 5, 5, 5, 5, 5, 5, 6, 0, 0, 1};
    sprite_address = 12'd0;
    for (int n = 0; n < 15; n++) begin
      frame_pulse(dirs[n]);
      tests_run++;
      if (anim_state !== st[n] || rom_addr !== 15'(idx[n] * 3600)) begin
        tests_failed++;
        $display("FAIL dir_change step%0d: state=%0d addr=%0d want %0d/%0d", n, anim_state, rom_addr, st[n], idx[n] * 3600);
      end
    end
  endtask

  task automatic test_reset_mid_pipeline();
    sprite_address = 12'd100; is_sprite = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    tests_run++;
    if (anim_state !== 2'd0 || rom_addr !== 15'd0 || pix_opaque !== 1'b0 || pix_index !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: state=%0d addr=%0d opq=%0b idx=%0d want all 0", anim_state, rom_addr, pix_opaque, pix_index);
    end
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      tests_run++;
      if (rom_addr !== 15'd100 || pix_opaque !== (c == 2) || pix_index !== ((c == 2) ? 4'd7 : 4'd0)) begin
        tests_failed++;
        $display("FAIL mid_reset_recover cyc%0d: addr=%0d opq=%0b idx=%0d", c, rom_addr, pix_opaque, pix_index);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lookup();
    test_back_to_back();
    test_walk_right();
    test_walk_left_wrap();
    test_direction_change();
    frame_pulse(4'd5);
    test_reset_mid_pipeline();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
